issue_cdb_scheduler: RTL and testbench

//  Issue-stage scheduler between the four reservation queues (INT, LD_ST, MULT, DIV) and their execution units.

---
 rtl/issue_cdb_scheduler_pkg.sv | 28 ++
 rtl/issue_cdb_scheduler_cdb_slot_calendar.sv | 80 ++++++++
 rtl/issue_cdb_scheduler.sv | 116 +++++++++++
 tb/tb_issue_cdb_scheduler.sv | 134 +++++++++++++
 4 files changed

// File: rtl/issue_cdb_scheduler_pkg.sv
// Shared types and default latencies for the issue-stage CDB scheduler.
package issue_cdb_scheduler_pkg;

  localparam int unsigned MULT_LAT_DEFAULT   = 4;
  localparam int unsigned DIV_LAT_DEFAULT    = 6;
  localparam int unsigned CAL_DEPTH_DEFAULT  = 8;
  localparam int unsigned STARVE_LIM_DEFAULT = 3;

  typedef enum logic [1:0] {
    INT_FIFO   = 2'd0,
    LD_ST_FIFO = 2'd1,
    MULT_FIFO  = 2'd2,
    DIV_FIFO   = 2'd3
  } fifo_data_type;

  typedef struct packed {
    logic int_en;
    logic mem_en;
    logic mult_en;
    logic div_en;
  } sched_grant_t;

  typedef enum logic {
    RR_INT = 1'b0,
    RR_MEM = 1'b1
  } rr_sel_t;

endpackage

// File: rtl/issue_cdb_scheduler_cdb_slot_calendar.sv
// CDB slot-reservation calendar: rsv[k]/own[k] describe bus ownership k cycles ahead.
module cdb_slot_calendar
  import issue_cdb_scheduler_pkg::*;
#(
  parameter int unsigned CAL_DEPTH = CAL_DEPTH_DEFAULT,
  parameter int unsigned NPORT     = 3,
  parameter int unsigned LW        = $clog2(CAL_DEPTH)
) (
  input  logic                 clk,
  input  logic                 clear,
  input  logic [NPORT-1:0]     res_valid,
  input  logic [LW-1:0]        res_lat   [NPORT],
  input  fifo_data_type        res_owner [NPORT],
  output logic [NPORT-1:0]     res_busy,
  output logic                 slot_valid,
  output fifo_data_type        slot_owner
);

  logic [CAL_DEPTH-1:0] rsv;
  logic [CAL_DEPTH-1:0] nxt_rsv;
  fifo_data_type        own     [CAL_DEPTH];
  fifo_data_type        nxt_own [CAL_DEPTH];
  logic [LW-1:0]        idx;

  // A grant with latency L lands in slot L-1 of the post-shift calendar.
  always_comb begin
    nxt_rsv = {1'b0, rsv[CAL_DEPTH-1:1]};
    idx     = '0;
    for (int unsigned k = 0; k < CAL_DEPTH - 1; k++) begin
      nxt_own[k] = own[k+1];
    end
    nxt_own[CAL_DEPTH-1] = INT_FIFO;
    for (int unsigned p = 0; p < NPORT; p++) begin
      if (res_valid[p]) begin
        idx          = res_lat[p] - LW'(1);
        nxt_rsv[idx] = 1'b1;
        nxt_own[idx] = res_owner[p];
      end
    end
  end

  always_comb begin
    res_busy = '0;
    for (int unsigned p = 0; p < NPORT; p++) begin
      res_busy[p] = rsv[res_lat[p]];
    end
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      rsv <= '0;
      for (int unsigned k = 0; k < CAL_DEPTH; k++) begin
        own[k] <= INT_FIFO;
      end
    end else begin
      rsv <= nxt_rsv;
      for (int unsigned k = 0; k < CAL_DEPTH; k++) begin
        own[k] <= nxt_own[k];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!clear) begin
      for (int unsigned p = 0; p < NPORT; p++) begin
        if (res_valid[p]) begin
          assert (!rsv[res_lat[p]]) else $error("calendar slot reserved twice");
          for (int unsigned q = p + 1; q < NPORT; q++) begin
            assert (!(res_valid[q] && res_lat[q] == res_lat[p]))
              else $error("two owners for one calendar slot");
          end
        end
      end
    end
  end

  assign slot_valid = rsv[0];
  assign slot_owner = own[0];

endmodule

// File: rtl/issue_cdb_scheduler.sv
// Issue-stage scheduler: grants per queue so no two results collide on the CDB.
module issue_cdb_scheduler
  import issue_cdb_scheduler_pkg::*;
#(
  parameter int unsigned MULT_LAT   = MULT_LAT_DEFAULT,
  parameter int unsigned DIV_LAT    = DIV_LAT_DEFAULT,
  parameter int unsigned CAL_DEPTH  = CAL_DEPTH_DEFAULT,
  parameter int unsigned STARVE_LIM = STARVE_LIM_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       flush,
  input  logic       int_issue_rdy,
  input  logic       mem_issue_rdy,
  input  logic       mult_issue_rdy,
  input  logic       div_issue_rdy,
  output logic       int_issue_en,
  output logic       mem_issue_en,
  output logic       mult_issue_en,
  output logic       div_issue_en,
  output logic       div_busy,
  output logic       cdb_sel_valid,
  output logic [1:0] cdb_sel
);

  localparam int unsigned LW = $clog2(CAL_DEPTH);
  localparam int unsigned CW = $clog2(DIV_LAT);
  localparam int unsigned SW = $clog2(STARVE_LIM + 1);

  sched_grant_t  grant;
  rr_sel_t       rr_ptr, rr_nxt;
  logic [CW-1:0] div_cnt;
  logic [SW-1:0] starve_cnt;
  logic          kill, hold_long;
  logic          int_ok, mem_ok;
  logic [2:0]    res_valid, res_busy;
  logic [LW-1:0] res_lat   [3];
  fifo_data_type res_owner [3];
  fifo_data_type slot_owner;

  assign kill      = rst | flush;
  assign hold_long = (starve_cnt == SW'(STARVE_LIM));
  assign div_busy  = (div_cnt != '0);
  assign int_ok    = int_issue_rdy & ~res_busy[0] & ~kill;
  assign mem_ok    = mem_issue_rdy & ~res_busy[0] & ~kill;

  always_comb begin
    grant  = '0;
    rr_nxt = rr_ptr;
    if (int_ok && mem_ok) begin
      if (rr_ptr == RR_INT) begin
        grant.int_en = 1'b1;
        rr_nxt       = RR_MEM;
      end else begin
        grant.mem_en = 1'b1;
        rr_nxt       = RR_INT;
      end
    end else begin
      grant.int_en = int_ok;
      grant.mem_en = mem_ok;
    end
    grant.mult_en = mult_issue_rdy & ~res_busy[1] & ~hold_long & ~kill;
    grant.div_en  = div_issue_rdy & ~res_busy[2] & ~div_busy & ~hold_long & ~kill;
  end

  // Port 0 is shared by INT and LD_ST; the round-robin guarantees one of them at most.
  assign res_valid    = {grant.div_en, grant.mult_en, grant.int_en | grant.mem_en};
  assign res_lat[0]   = LW'(1);
  assign res_lat[1]   = LW'(MULT_LAT);
  assign res_lat[2]   = LW'(DIV_LAT);
  assign res_owner[0] = grant.mem_en ? LD_ST_FIFO : INT_FIFO;
  assign res_owner[1] = MULT_FIFO;
  assign res_owner[2] = DIV_FIFO;

  cdb_slot_calendar #(
    .CAL_DEPTH (CAL_DEPTH),
    .NPORT     (3),
    .LW        (LW)
  ) u_calendar (
    .clk        (clk),
    .clear      (kill),
    .res_valid  (res_valid),
    .res_lat    (res_lat),
    .res_owner  (res_owner),
    .res_busy   (res_busy),
    .slot_valid (cdb_sel_valid),
    .slot_owner (slot_owner)
  );

  always_ff @(posedge clk) begin
    if (kill) begin
      rr_ptr     <= RR_INT;
      div_cnt    <= '0;
      starve_cnt <= '0;
    end else begin
      rr_ptr <= rr_nxt;
      if (grant.div_en) begin
        div_cnt <= CW'(DIV_LAT - 1);
      end else if (div_busy) begin
        div_cnt <= div_cnt - CW'(1);
      end
      if (grant.int_en || grant.mem_en || !(int_issue_rdy || mem_issue_rdy)) begin
        starve_cnt <= '0;
      end else if (!hold_long) begin
        starve_cnt <= starve_cnt + SW'(1);
      end
    end
  end

  assign int_issue_en  = grant.int_en;
  assign mem_issue_en  = grant.mem_en;
  assign mult_issue_en = grant.mult_en;
  assign div_issue_en  = grant.div_en;
  assign cdb_sel       = slot_owner;

endmodule

// File: tb/tb_issue_cdb_scheduler.sv
// Directed table-driven bench for issue_cdb_scheduler plus starvation and reset sequences.
module tb_issue_cdb_scheduler;

  logic       clk = 1'b0;
  logic       rst, flush;
  logic       int_rdy, mem_rdy, mult_rdy, div_rdy;
  logic       int_en, mem_en, mult_en, div_en;
  logic       div_busy, cdb_v;
  logic [1:0] cdb_sel;

  int unsigned passed = 0;
  int unsigned total  = 0;

  // in = {rst, flush, int, mem, mult, div}; ex = {int_en, mem_en, mult_en, div_en, div_busy, cdb_valid}
  typedef struct packed {
    logic [5:0] in;
    logic [5:0] ex;
    logic [1:0] sel;
  } vec_t;

  vec_t vecs [32];

  always #5 clk = ~clk;

  issue_cdb_scheduler #(
    .MULT_LAT   (4),
    .DIV_LAT    (6),
    .CAL_DEPTH  (8),
    .STARVE_LIM (3)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .flush          (flush),
    .int_issue_rdy  (int_rdy),
    .mem_issue_rdy  (mem_rdy),
    .mult_issue_rdy (mult_rdy),
    .div_issue_rdy  (div_rdy),
    .int_issue_en   (int_en),
    .mem_issue_en   (mem_en),
    .mult_issue_en  (mult_en),
    .div_issue_en   (div_en),
    .div_busy       (div_busy),
    .cdb_sel_valid  (cdb_v),
    .cdb_sel        (cdb_sel)
  );

  task automatic chk(input string name, input logic [1:0] act, input logic [1:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic apply(input logic [5:0] in);
    @(negedge clk);
    {rst, flush, int_rdy, mem_rdy, mult_rdy, div_rdy} = in;
    #1;
  endtask

  task automatic check_all(input string tag, input logic [5:0] ex, input logic [1:0] sel);
    chk($sformatf("%s.int_en", tag),   {1'b0, int_en},   {1'b0, ex[5]});
    chk($sformatf("%s.mem_en", tag),   {1'b0, mem_en},   {1'b0, ex[4]});
    chk($sformatf("%s.mult_en", tag),  {1'b0, mult_en},  {1'b0, ex[3]});
    chk($sformatf("%s.div_en", tag),   {1'b0, div_en},   {1'b0, ex[2]});
    chk($sformatf("%s.div_busy", tag), {1'b0, div_busy}, {1'b0, ex[1]});
    chk($sformatf("%s.cdb_valid", tag), {1'b0, cdb_v},   {1'b0, ex[0]});
    chk($sformatf("%s.cdb_sel", tag),  cdb_sel,          sel);
  endtask

  initial begin
    logic [10:0] exp_ie;
    logic [10:0] exp_mue;

    // reset with every queue ready: no grants, reset outputs
    vecs[0]  = '{6'b111111, 6'b000000, 2'd0};
    // INT/LD_ST round-robin
    vecs[1]  = '{6'b001100, 6'b100000, 2'd0};
    vecs[2]  = '{6'b001100, 6'b010001, 2'd0};
    vecs[3]  = '{6'b001100, 6'b100001, 2'd1};
    vecs[4]  = '{6'b001100, 6'b010001, 2'd0};
    vecs[5]  = '{6'b000000, 6'b000001, 2'd1};
    vecs[6]  = '{6'b000000, 6'b000000, 2'd0};
    // mult at t0, int from t2: slot t4 owned by mult blocks int at t3
    vecs[7]  = '{6'b000010, 6'b001000, 2'd0};
    vecs[8]  = '{6'b000000, 6'b000000, 2'd0};
    vecs[9]  = '{6'b001000, 6'b100000, 2'd0};
    vecs[10] = '{6'b001000, 6'b000001, 2'd0};
    vecs[11] = '{6'b001000, 6'b100001, 2'd2};
    vecs[12] = '{6'b000000, 6'b000001, 2'd0};
    vecs[13] = '{6'b000000, 6'b000000, 2'd0};
    // divider serialisation: grants at t0 and t6
    vecs[14] = '{6'b000001, 6'b000100, 2'd0};
    for (int i = 15; i < 20; i++) vecs[i] = '{6'b000001, 6'b000010, 2'd0};
    vecs[20] = '{6'b000001, 6'b000101, 2'd3};
    vecs[21] = '{6'b000000, 6'b000010, 2'd0};
    vecs[22] = '{6'b011001, 6'b000010, 2'd0};
    vecs[23] = '{6'b000000, 6'b000000, 2'd0};
    // mult t0, div t1, flush t2: nothing reaches the bus
    vecs[24] = '{6'b000010, 6'b001000, 2'd0};
    vecs[25] = '{6'b000001, 6'b000100, 2'd0};
    vecs[26] = '{6'b011011, 6'b000010, 2'd0};
    for (int i = 27; i < 32; i++) vecs[i] = '{6'b000000, 6'b000000, 2'd0};

    {rst, flush, int_rdy, mem_rdy, mult_rdy, div_rdy} = 6'b100000;
    repeat (2) @(posedge clk);

    for (int i = 0; i < 32; i++) begin
      apply(vecs[i].in);
      check_all($sformatf("row%0d", i), vecs[i].ex, vecs[i].sel);
    end

    // starvation: mult keeps taking int's slot from t3; hold from t6, int wins at t9
    exp_ie  = 11'b11000000111;
    exp_mue = 11'b10000111111;
    for (int t = 0; t < 11; t++) begin
      apply(6'b001010);
      chk($sformatf("starve.t%0d.int_en", t),  {1'b0, int_en},  {1'b0, exp_ie[t]});
      chk($sformatf("starve.t%0d.mult_en", t), {1'b0, mult_en}, {1'b0, exp_mue[t]});
    end

    // reset mid-stream with reservations pending
    apply(6'b111111);
    check_all("rst_mid", 6'b000001, 2'd0);
    apply(6'b001000);
    check_all("post_rst", 6'b100000, 2'd0);
    for (int t = 0; t < 3; t++) begin
      apply(6'b000000);
      check_all($sformatf("post_rst_idle%0d", t), 6'b000001 & {5'b0, t == 0}, 2'd0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
